// File: rtl/frame_pkg.sv
// Shared types and constants for the UART byte-stream frame decoder.
package frame_pkg;

  typedef enum logic [2:0] {
    FD_IDLE,
    FD_A1,
    FD_A0,
    FD_L1,
    FD_L0,
    FD_PAYLOAD,
    FD_CKSUM
  } fd_state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // Address hi/lo plus length hi/lo follow every sync byte.
  localparam int unsigned HDR_BYTES = 4;

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte idle counter for the frame decoder; built only with FRAME_TIMEOUT_EN.
module byte_timeout #(
  parameter int timeout_cycles = 19000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(timeout_cycles + 1);
  localparam logic [CW-1:0] LAST = CW'(timeout_cycles - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count;

  // A byte in the expiry cycle wins, so clear masks the strobe.
  assign expired = enable && !clear && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear || !enable) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/frame_decoder.sv
// Sync-hunting byte framer: header parse, payload write strobes, trailing checksum.
// Optional inter-byte abort timer enabled by defining FRAME_TIMEOUT_EN.
module frame_decoder
  import frame_pkg::*;
#(
  parameter int         addr_size      = 10,
  parameter int         len_size       = 16,
  parameter logic [7:0] sync_byte      = SYNC_DEFAULT,
  parameter int         timeout_cycles = 19000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           data,
  input  logic                 data_ready,
  output logic                 ready,
  output logic [addr_size-1:0] addr,
  output logic [len_size-1:0]  length,
  output logic [7:0]           data_out,
  output logic                 write_strobe,
  output logic                 frame_ok,
  output logic                 frame_err
);

  localparam logic [addr_size-1:0] ADDR_ONE = addr_size'(1);
  localparam logic [len_size-1:0]  LEN_ONE  = len_size'(1);

  fd_state_t            state;
  fd_state_t            state_next;
  logic [7:0]           hi_byte;
  logic [7:0]           sum;
  logic [7:0]           sum_next;
  logic [15:0]          hdr_word;
  logic [len_size-1:0]  len_word;
  logic [len_size-1:0]  remaining;
  logic                 timeout_hit;

`ifdef FRAME_TIMEOUT_EN
  byte_timeout #(
    .timeout_cycles(timeout_cycles)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (data_ready),
    .enable (state != FD_IDLE),
    .expired(timeout_hit)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_cycles;
  assign timeout_hit    = 1'b0;
`endif

  assign hdr_word = {hi_byte, data};
  assign len_word = hdr_word[len_size-1:0];
  assign sum_next = sum + data;

  always_comb begin
    state_next = state;
    if (data_ready) begin
      case (state)
        FD_IDLE:    if (data == sync_byte) state_next = FD_A1;
        FD_A1:      state_next = FD_A0;
        FD_A0:      state_next = FD_L1;
        FD_L1:      state_next = FD_L0;
        FD_L0:      state_next = (len_word == '0) ? FD_CKSUM : FD_PAYLOAD;
        FD_PAYLOAD: if (remaining == LEN_ONE) state_next = FD_CKSUM;
        FD_CKSUM:   state_next = FD_IDLE;
        default:    state_next = FD_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_next = FD_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= FD_IDLE;
      hi_byte      <= '0;
      sum          <= '0;
      remaining    <= '0;
      addr         <= '0;
      length       <= '0;
      data_out     <= '0;
      ready        <= 1'b0;
      write_strobe <= 1'b0;
      frame_ok     <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_next;
      ready        <= 1'b0;
      write_strobe <= 1'b0;
      frame_ok     <= 1'b0;
      frame_err    <= timeout_hit;
      // addr names the current strobe's target, so step it once that strobe is out.
      if (write_strobe) addr <= addr + ADDR_ONE;
      if (data_ready) begin
        case (state)
          FD_IDLE: begin
            if (data == sync_byte) begin
              ready <= 1'b1;
              sum   <= '0;
            end
          end
          FD_A1: begin
            hi_byte <= data;
            sum     <= sum_next;
          end
          FD_A0: begin
            addr <= hdr_word[addr_size-1:0];
            sum  <= sum_next;
          end
          FD_L1: begin
            hi_byte <= data;
            sum     <= sum_next;
          end
          FD_L0: begin
            length    <= len_word;
            remaining <= len_word;
            sum       <= sum_next;
          end
          FD_PAYLOAD: begin
            data_out     <= data;
            write_strobe <= 1'b1;
            remaining    <= remaining - LEN_ONE;
            sum          <= sum_next;
          end
          FD_CKSUM: begin
            if (sum_next == 8'h00) frame_ok  <= 1'b1;
            else                   frame_err <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_decoder.sv
// Directed bench for frame_decoder: expected pulse events queued at drive time, popped by a monitor.
module tb_frame_decoder;
  import frame_pkg::*;

  localparam int AW = 10;
  localparam int LW = 16;
  localparam int W  = 3 + AW + 8;
  localparam logic [2:0] EV_READY = 3'd1;
  localparam logic [2:0] EV_WR    = 3'd2;
  localparam logic [2:0] EV_OK    = 3'd3;
  localparam logic [2:0] EV_ERR   = 3'd4;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    data;
  logic          data_ready;
  logic          ready;
  logic [AW-1:0] addr;
  logic [LW-1:0] length;
  logic [7:0]    data_out;
  logic          write_strobe;
  logic          frame_ok;
  logic          frame_err;

  int            checks   = 0;
  int            failures = 0;
  bit            mon_en   = 1'b0;
  logic [W-1:0]  exp_q[$];
  logic [7:0]    pay_q[$];

  // ---------------- clock / reset
  always #5 clk = ~clk;

  frame_decoder #(
    .addr_size     (AW),
    .len_size      (LW),
    .sync_byte     (SYNC_DEFAULT),
    .timeout_cycles(100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data        (data),
    .data_ready  (data_ready),
    .ready       (ready),
    .addr        (addr),
    .length      (length),
    .data_out    (data_out),
    .write_strobe(write_strobe),
    .frame_ok    (frame_ok),
    .frame_err   (frame_err)
  );

  function automatic logic [W-1:0] ev(logic [2:0] k, logic [AW-1:0] a, logic [7:0] d);
    return {k, a, d};
  endfunction

  task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // ---------------- driver tasks
  task automatic send_byte(logic [7:0] b);
    data       = b;
    data_ready = 1'b1;
    @(posedge clk);
    #1;
    data_ready = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queues every expected event from a reference model, then drives the frame from pay_q.
  task automatic send_frame(logic [15:0] a16, bit force_c, logic [7:0] forced_c);
    logic [15:0]   l16;
    logic [7:0]    s;
    logic [7:0]    c;
    logic [AW-1:0] am;
    l16 = 16'(pay_q.size());
    s   = a16[15:8] + a16[7:0] + l16[15:8] + l16[7:0];
    am  = a16[AW-1:0];
    exp_q.push_back(ev(EV_READY, '0, '0));
    foreach (pay_q[i]) begin
      exp_q.push_back(ev(EV_WR, am, pay_q[i]));
      am = am + 1'b1;
      s  = s + pay_q[i];
    end
    c = force_c ? forced_c : (8'h00 - s);
    exp_q.push_back((8'(s + c) == 8'h00) ? ev(EV_OK, '0, '0) : ev(EV_ERR, '0, '0));
    send_byte(SYNC_DEFAULT);
    send_byte(a16[15:8]);
    send_byte(a16[7:0]);
    check("hdr_addr", 32'(addr), 32'(a16[AW-1:0]));
    send_byte(l16[15:8]);
    send_byte(l16[7:0]);
    check("hdr_length", 32'(length), 32'(l16));
    foreach (pay_q[i]) send_byte(pay_q[i]);
    send_byte(c);
  endtask

  // ---------------- scoreboard monitor
  always @(negedge clk) begin : monitor
    int           n;
    logic [W-1:0] obs;
    logic [W-1:0] expv;
    if (mon_en) begin
      n = int'(ready) + int'(write_strobe) + int'(frame_ok) + int'(frame_err);
      if (n > 1) check("pulse_exclusive", 32'(n), 32'd1);
      if (n != 0) begin
        if (ready)             obs = ev(EV_READY, '0, '0);
        else if (write_strobe) obs = ev(EV_WR, addr, data_out);
        else if (frame_ok)     obs = ev(EV_OK, '0, '0);
        else                   obs = ev(EV_ERR, '0, '0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 32'(obs), 32'd0);
        end else begin
          expv = exp_q.pop_front();
          check("event", 32'(obs), 32'(expv));
        end
      end
    end
  end

  // ---------------- directed sequence
  initial begin
    reset      = 1'b1;
    data       = '0;
    data_ready = 1'b0;
    idle(3);
    check("reset_outputs",
          32'({addr, length, data_out, ready, write_strobe, frame_ok, frame_err}), 32'd0);
    mon_en = 1'b1;
    reset  = 1'b0;
    idle(2);

    // Basic frame, good checksum.
    pay_q = '{8'h11, 8'h22, 8'h33};
    send_frame(16'h0010, 1'b0, 8'h00);
    idle(3);

    // Same frame with checksum 00 -> error; a following sync must still be accepted.
    send_frame(16'h0010, 1'b1, 8'h00);
    idle(3);

    // Noise before sync, address wrap at the top of the address space.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    pay_q = '{8'h5A, 8'hC3};
    send_frame(16'h03FF, 1'b0, 8'h00);
    check("addr_after_wrap", 32'(addr), 32'h001);
    idle(3);

    // Zero-length frame goes straight to the checksum byte.
    pay_q.delete();
    send_frame(16'h0000, 1'b0, 8'h00);
    idle(3);

    // Sync value inside the payload is plain data.
    pay_q = '{8'hA5, 8'h01, 8'hA5};
    send_frame(16'h0100, 1'b0, 8'h00);
    idle(3);

    // Reset after the second payload byte abandons the frame.
    exp_q.push_back(ev(EV_READY, '0, '0));
    exp_q.push_back(ev(EV_WR, 10'h020, 8'h44));
    exp_q.push_back(ev(EV_WR, 10'h021, 8'h55));
    send_byte(SYNC_DEFAULT);
    send_byte(8'h00);
    send_byte(8'h20);
    send_byte(8'h00);
    send_byte(8'h04);
    send_byte(8'h44);
    send_byte(8'h55);
    reset = 1'b1;
    idle(1);
    check("midframe_reset_outputs",
          32'({addr, length, data_out, ready, write_strobe, frame_ok, frame_err}), 32'd0);
    check("midframe_reset_events", 32'(exp_q.size()), 32'd0);
    reset = 1'b0;
    idle(2);
    pay_q = '{8'h66, 8'h77};
    send_frame(16'h0040, 1'b0, 8'h00);
    idle(3);

`ifdef FRAME_TIMEOUT_EN
    // Stall 100 clocks mid-header -> abort.
    exp_q.push_back(ev(EV_READY, '0, '0));
    exp_q.push_back(ev(EV_ERR, '0, '0));
    send_byte(SYNC_DEFAULT);
    send_byte(8'h00);
    idle(100);
    idle(3);
    check("timeout_events", 32'(exp_q.size()), 32'd0);

    // Byte landing exactly on the expiry clock is accepted.
    exp_q.push_back(ev(EV_READY, '0, '0));
    exp_q.push_back(ev(EV_WR, 10'h010, 8'h99));
    exp_q.push_back(ev(EV_OK, '0, '0));
    send_byte(SYNC_DEFAULT);
    send_byte(8'h00);
    idle(99);
    send_byte(8'h10);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h99);
    send_byte(8'h56);
    idle(3);
`endif

    idle(5);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
